// File: rtl/sine_plot_gen.sv
// sine_plot_gen: on each tick, streams one 16x16 frame of a sine curve to a frame buffer, then requests a swap.
// Optional build macro SINE_PLOT_FILL_EN shades pixels below the curve at level 1.
module sine_plot_gen #(
    parameter int TICK_DIV   = 100000,
    parameter int PHASE_STEP = 1,
    parameter int X_STEP     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic [3:0] wr_x,
    output logic [3:0] wr_y,
    output logic [1:0] wr_level,
    output logic       swap_req,
    input  logic       swap_ack,
    output logic [7:0] overrun_cnt
);
    localparam int CW = $clog2(TICK_DIV);

    // floor(7.5 + 7.5*sin(2*pi*i/64) + 0.5)
    localparam logic [3:0] LUT [64] = '{
        4'd8,  4'd8,  4'd9,  4'd10, 4'd10, 4'd11, 4'd12, 4'd12,
        4'd13, 4'd13, 4'd14, 4'd14, 4'd14, 4'd15, 4'd15, 4'd15,
        4'd15, 4'd15, 4'd15, 4'd15, 4'd14, 4'd14, 4'd14, 4'd13,
        4'd13, 4'd12, 4'd12, 4'd11, 4'd10, 4'd10, 4'd9,  4'd8,
        4'd8,  4'd7,  4'd6,  4'd5,  4'd5,  4'd4,  4'd3,  4'd3,
        4'd2,  4'd2,  4'd1,  4'd1,  4'd1,  4'd0,  4'd0,  4'd0,
        4'd0,  4'd0,  4'd0,  4'd0,  4'd1,  4'd1,  4'd1,  4'd2,
        4'd2,  4'd3,  4'd3,  4'd4,  4'd5,  4'd5,  4'd6,  4'd7
    };

    typedef enum logic [1:0] {IDLE, RENDER, SWAP} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] tick_cnt;
    logic          tick, pending, xfer, last_px;
    logic [5:0]    phase, idx;
    logic [3:0]    h, curve_row;

    assign tick    = (tick_cnt == CW'(TICK_DIV - 1));
    assign xfer    = wr_valid && wr_ready;
    assign last_px = (wr_x == 4'd15) && (wr_y == 4'd15);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // wr_valid is a decode of RENDER, so it rises the cycle after IDLE saw the tick.
    always_comb begin
        state_nx = state;
        wr_valid = 1'b0;
        swap_req = 1'b0;
        case (state)
            IDLE:    if (tick || pending) state_nx = RENDER;
            RENDER: begin
                wr_valid = 1'b1;
                if (xfer && last_px) state_nx = SWAP;
            end
            SWAP: begin
                swap_req = 1'b1;
                if (swap_ack) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // IDLE consumes pending; a coincident tick re-arms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= 1'b0;
            overrun_cnt <= 8'd0;
        end else if (state == IDLE) begin
            pending <= pending && tick;
        end else if (tick) begin
            if (!pending)                  pending     <= 1'b1;
            else if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_x  <= 4'd0;
            wr_y  <= 4'd0;
            phase <= 6'd0;
        end else begin
            // Raster counter wraps back to (0,0) after the last pixel.
            if (xfer) {wr_y, wr_x} <= {wr_y, wr_x} + 8'd1;
            if (state == SWAP && swap_ack) phase <= phase + 6'(PHASE_STEP);
        end
    end

    assign idx       = phase + 6'(int'(wr_x) * X_STEP);
    assign h         = LUT[idx];
    assign curve_row = 4'd15 - h;

    always_comb begin
        wr_level = 2'd0;
        if (wr_valid) begin
            if (wr_y == curve_row) wr_level = 2'd3;
`ifdef SINE_PLOT_FILL_EN
            else if (wr_y > curve_row) wr_level = 2'd1;
`else
            else wr_level = 2'd0;
`endif
        end
    end
endmodule

// File: tb/tb_sine_plot_gen.sv
// Randomized bench for sine_plot_gen against a cycle-level behavioural model built from real-valued sine math.
module tb_sine_plot_gen;
    localparam int TD = 20;
    localparam int PS = 16;
    localparam int XS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_ready = 1'b0;
    logic       swap_ack = 1'b0;
    logic       wr_valid, swap_req;
    logic [3:0] wr_x, wr_y;
    logic [1:0] wr_level;
    logic [7:0] overrun_cnt;

    sine_plot_gen #(.TICK_DIV(TD), .PHASE_STEP(PS), .X_STEP(XS)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_level(wr_level), .swap_req(swap_req),
        .swap_ack(swap_ack), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int lut [64];

    // model state: cycles since release, pixel index, completed frames, pending, overruns
    int m_cyc = 0, m_k = 0, m_frame = 0, m_pend = 0, m_ovr = 0;
    bit m_render = 1'b0, m_swap = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lut_ref(input int i);
        real v;
        v = 7.5 + 7.5 * $sin(2.0 * 3.14159265358979 * i / 64.0) + 0.5 + 1.0e-9;
        return int'($floor(v));
    endfunction

    function automatic int exp_level(input int ph, input int x, input int y);
        int row;
        row = 15 - lut[(ph + x * XS) % 64];
        if (y == row) return 3;
`ifdef SINE_PLOT_FILL_EN
        if (y > row) return 1;
`endif
        return 0;
    endfunction

    always @(negedge clk) begin
        bit tick, idle;
        int x, y;
        if (!rst_n) begin
            chk("rst_valid", int'(wr_valid), 0);
            chk("rst_swap", int'(swap_req), 0);
            chk("rst_xy", int'({wr_y, wr_x}), 0);
            chk("rst_level", int'(wr_level), 0);
            chk("rst_ovr", int'(overrun_cnt), 0);
            m_cyc = 0; m_k = 0; m_frame = 0; m_pend = 0; m_ovr = 0;
            m_render = 1'b0; m_swap = 1'b0;
        end else begin
            x = m_k % 16;
            y = m_k / 16;
            chk("valid", int'(wr_valid), int'(m_render));
            chk("swap_req", int'(swap_req), int'(m_swap));
            chk("overrun", int'(overrun_cnt), m_ovr);
            if (m_render) begin
                chk("wr_x", int'(wr_x), x);
                chk("wr_y", int'(wr_y), y);
                chk("level", int'(wr_level), exp_level((m_frame * PS) % 64, x, y));
                // hand-computed points that pin the model
                if (m_frame == 0 && m_k == 0)   chk("lit_px_0_0", int'(wr_level), 0);
                if (m_frame == 0 && m_k == 112) chk("lit_px_0_7", int'(wr_level), 3);
                if (m_frame == 0 && m_k == 4)   chk("lit_px_4_0", int'(wr_level), 3);
                if (m_frame == 0 && m_k == 252) chk("lit_px_12_15", int'(wr_level), 3);
`ifdef SINE_PLOT_FILL_EN
                if (m_frame == 0 && m_k == 128) chk("lit_fill_0_8", int'(wr_level), 1);
                if (m_frame == 0 && m_k == 96)  chk("lit_fill_0_6", int'(wr_level), 0);
`else
                if (m_frame == 0 && m_k == 128) chk("lit_nofill_0_8", int'(wr_level), 0);
`endif
                if (m_frame == 1 && m_k == 0)   chk("lit_f1_px_0_0", int'(wr_level), 3);
            end

            tick = (m_cyc % TD) == TD - 1;
            idle = !m_render && !m_swap;
            if (m_render) begin
                if (wr_ready) begin
                    m_k++;
                    if (m_k == 256) begin
                        m_k = 0; m_render = 1'b0; m_swap = 1'b1;
                    end
                end
            end else if (m_swap) begin
                if (swap_ack) begin
                    m_swap = 1'b0; m_frame++;
                end
            end else if (tick || m_pend != 0) begin
                m_render = 1'b1;
            end
            if (idle) m_pend = (m_pend != 0 && tick) ? 1 : 0;
            else if (tick) begin
                if (m_pend == 0)     m_pend = 1;
                else if (m_ovr < 255) m_ovr++;
            end
            m_cyc++;
        end
    end

    task automatic run_frames(input int target, input int ready_pct, input int ack_div, input int limit);
        int n;
        n = 0;
        while (m_frame < target && n < limit) begin
            @(posedge clk);
            #1;
            wr_ready = ($urandom_range(99) < ready_pct);
            swap_ack = !swap_ack && ($urandom_range(ack_div - 1) == 0);
            n++;
        end
        if (m_frame < target) begin
            total++; bad++;
            $display("FAIL frame_timeout: got %0d frames expected %0d", m_frame, target);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 64; i++) lut[i] = lut_ref(i);
        chk("lut_0", lut[0], 8);
        chk("lut_16", lut[16], 15);
        chk("lut_32", lut[32], 8);
        chk("lut_48", lut[48], 0);
        chk("lut_3", lut[3], 10);
        chk("lut_40", lut[40], 2);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_frames(2, 100, 2, 4000);
        run_frames(5, 50, 50, 8000);

        // async reset in the middle of a frame
        n = 0;
        while (!(m_render && m_k == 100) && n < 4000) begin
            @(posedge clk);
            #1;
            wr_ready = ($urandom_range(99) < 60);
            swap_ack = !swap_ack && ($urandom_range(9) == 0);
            n++;
        end
        if (!(m_render && m_k == 100)) begin
            total++; bad++;
            $display("FAIL wait_px100: pixel 100 never reached");
        end
        #2 rst_n = 1'b0;
        #1;
        chk("imm_valid", int'(wr_valid), 0);
        chk("imm_xy", int'({wr_y, wr_x}), 0);
        chk("imm_swap", int'(swap_req), 0);
        chk("imm_ovr", int'(overrun_cnt), 0);
        wr_ready = 1'b0;
        swap_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_frames(14, 50, 40, 20000);
        chk("ovr_saturated", int'(overrun_cnt), 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
